// File: rtl/two_byte_mem_cmd_driver.sv
// Host-side command driver for the two-register CPLD interface (nibble + strobe, int_wait handshake).
// Optional post-write readback is enabled by defining CMD_DRIVER_READBACK_EN.
module two_byte_mem_cmd_driver #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int WAIT_TMO  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic       req_sel,
  input  logic [3:0] req_val,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] rsp_data,
  output logic [3:0] pc_out,
  output logic       en_out,
  input  logic       int_wait,
  input  logic [7:0] rd_data
);

  localparam int CW = 8;
  localparam logic [CW-1:0] SETUP_L = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_L = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_L  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TMO_L   = CW'(WAIT_TMO - 1);

  // C_* command nibble, V_* value nibble, R_* readback command; W_* wait on synchronized int_wait
  typedef enum logic [3:0] {
    IDLE, C_SETUP, C_PULSE, C_HOLD, W_ACK, V_SETUP, V_PULSE, V_HOLD,
    W_DONE, R_SETUP, R_PULSE, R_HOLD, RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      pc_q, pc_d;
  logic            err_q, err_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      op_q, op_d;
  logic            sel_q, sel_d;
  logic [3:0]      val_q, val_d;
  logic            wait_m, wait_s;
  logic            cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      op_q    <= '0;
      sel_q   <= 1'b0;
      val_q   <= '0;
      wait_m  <= 1'b0;
      wait_s  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      data_q  <= data_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      wait_m  <= int_wait;
      wait_s  <= wait_m;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    err_d   = err_q;
    data_d  = data_q;
    op_d    = op_q;
    sel_d   = sel_q;
    val_d   = val_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          sel_d  = req_sel;
          val_d  = req_val;
          err_d  = 1'b0;
          data_d = '0;
          if (req_op >= 3'd6) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            pc_d    = {req_op, req_sel};
            cnt_d   = SETUP_L;
            state_d = C_SETUP;
          end
        end
      end
      C_SETUP, V_SETUP, R_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = PULSE_L;
          state_d = (state_q == C_SETUP) ? C_PULSE :
                    (state_q == V_SETUP) ? V_PULSE : R_PULSE;
        end else cnt_d = cnt_q - CW'(1);
      end
      C_PULSE, V_PULSE, R_PULSE: begin
        if (cnt_zero) begin
          cnt_d   = HOLD_L;
          state_d = (state_q == C_PULSE) ? C_HOLD :
                    (state_q == V_PULSE) ? V_HOLD : R_HOLD;
        end else cnt_d = cnt_q - CW'(1);
      end
      C_HOLD: begin
        if (cnt_zero) begin
          if (op_q == 3'd3) begin
            cnt_d   = TMO_L;
            state_d = W_ACK;
          end else begin
            if (op_q == 3'd5) data_d = rd_data;
            state_d = RESP;
          end
        end else cnt_d = cnt_q - CW'(1);
      end
      W_ACK: begin
        if (wait_s) begin
          pc_d    = val_q;
          cnt_d   = SETUP_L;
          state_d = V_SETUP;
        end else if (cnt_zero) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else cnt_d = cnt_q - CW'(1);
      end
      V_HOLD: begin
        if (cnt_zero) begin
          cnt_d   = TMO_L;
          state_d = W_DONE;
        end else cnt_d = cnt_q - CW'(1);
      end
      W_DONE: begin
        if (!wait_s) begin
`ifdef CMD_DRIVER_READBACK_EN
          pc_d    = {3'b101, sel_q};
          cnt_d   = SETUP_L;
          state_d = R_SETUP;
`else
          state_d = RESP;
`endif
        end else if (cnt_zero) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else cnt_d = cnt_q - CW'(1);
      end
      R_HOLD: begin
        if (cnt_zero) begin
          data_d = rd_data;
          if (rd_data != {4'h0, val_q}) err_d = 1'b1;
          state_d = RESP;
        end else cnt_d = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_data  = rsp_valid ? data_q : 8'h00;
  assign pc_out    = pc_q;
  assign en_out    = (state_q == C_PULSE) || (state_q == V_PULSE) || (state_q == R_PULSE);

endmodule
